seq_player: RTL and testbench
=============================

Name: seq_player

Overview:
Playback engine for the "Sly Man Says" pattern.
- On `start`, regenerates the pseudo-random colour sequence from a game seed.
- Plays the first `round_len` steps on four one-hot LEDs, with a fixed on-time and gap per step.
- Exposes the current step index, which feeds the 6-bit step counter and the input checker downstream.
- Same seed gives the same sequence every round, so each new round only extends the pattern by one step.

Parameters:
ON_CYCLES, 25000000, clk cycles each LED is lit per step (>=1)
OFF_CYCLES, 12500000, clk cycles of dark gap after each step (>=1)
TIMER_W, 26, width of the on/off down-counter; must hold max(ON_CYCLES,OFF_CYCLES)-1
DEFAULT_SEED, 16'hACE1, substituted when seed input is zero

Ports:
clk  input  1  system clock, all state on rising edge
clr  input  1  asynchronous active-high reset
start  input  1  request playback; sampled only in IDLE
round_len  input  6  number of steps to play, 0..63; latched in LOAD
seed  input  16  LFSR seed; latched in LOAD
led  output  4  one-hot colour while lit, 4'b0000 otherwise
step_idx  output  6  index of the step being played, 0-based
busy  output  1  high from LOAD through last GAP
done  output  1  single-cycle pulse at end of playback

Behaviour:
- One clock (`clk`); reset `clr` is asynchronous and active-high. All registers clear immediately on `clr`, independent of `clk`.
- Reset values: state=IDLE, led=0, step_idx=0, busy=0, done=0, lfsr=0, timer=0, len_q=0.
- LFSR: 16-bit Fibonacci register.
  - Step rule: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Colour = lfsr[1:0]; led = 1 << colour.
  - The LFSR advances exactly once per step, on the ON->GAP transition.
- States are IDLE, LOAD, ON, GAP, DONE.
  - IDLE: outputs 0.
    - start=1 and round_len!=0 -> LOAD.
    - start=1 and round_len==0 -> DONE directly; busy never rises, no LED lit.
  - LOAD (1 cycle): busy=1; len_q<=round_len; lfsr<=(seed==0 ? DEFAULT_SEED : seed); step_idx<=0 -> ON.
    - On entry to ON: timer<=ON_CYCLES-1; led<=1<<lfsr[1:0] (colour taken from the freshly loaded LFSR).
  - ON: led held; timer decrements each cycle.
    - At timer==0 -> GAP: led<=0, timer<=OFF_CYCLES-1, LFSR steps.
  - GAP: timer decrements.
    - At timer==0 and step_idx==len_q-1 -> DONE.
    - Otherwise step_idx<=step_idx+1 -> ON, using the colour of the advanced LFSR.
  - DONE (1 cycle): done=1, busy=0, led=0 -> IDLE. step_idx keeps the last index until the next LOAD.
- Latency: start high in cycle 0 ->
  - busy high from cycle 1;
  - step k lit in cycles 2+k*(ON+OFF) .. 2+k*(ON+OFF)+ON-1;
  - done high only in cycle 2+len*(ON+OFF).
- Boundaries:
  - start while busy or in DONE: ignored, no restart.
  - round_len or seed changing after LOAD: no effect on the current playback.
  - round_len=63: step_idx reaches 62 and never wraps.
  - clr mid-step: led goes 0 immediately; next start replays from step 0.
  - Never more than one LED lit; led=0 in every non-ON state.

Decomposition:
- Shared package `sms_pkg`:
  - state encoding (IDLE=0, LOAD=1, ON=2, GAP=3, DONE=4, 3-bit);
  - LFSR tap positions;
  - DEFAULT_SEED;
  - colour-to-LED one-hot constants.
- One sub-module, `lfsr16`: ports clk, clr, load, seed[15:0], step, q[15:0]. `load` has priority over `step`. The same module is reused by the input checker so both blocks generate identical sequences.

Test Plan:
- ON=4, OFF=2, seed=16'h0001, round_len=4, pulse start -> led sequence 0010, 0100, 0001, 0001, each 4 cycles then 2 dark; step_idx 0..3; done in cycle 26.
- seed=0, round_len=1 -> identical to seed=16'hACE1: led=0010 (ACE1[1:0]=01) for 4 cycles; done in cycle 8.
- round_len=0 with start -> done pulses for one cycle, busy stays 0, led stays 0.
- start re-asserted at cycle 10 of a 4-step playback, and round_len changed to 2 -> no restart; still 4 steps; done in cycle 26.
- Assert clr at cycle 5 (led lit) -> led=0, busy=0, step_idx=0 immediately without a clk edge; a new start replays from step 0 with the same colours.
- round_len=63, ON=1, OFF=1 -> step_idx ends at 62; done in cycle 128; exactly 63 ON pulses, each with a single LED bit set.

Source files
------------

// File: rtl/sms_pkg.sv
// Shared definitions for the Sly Man Says playback engine and input checker:
// state encoding, LFSR taps, default seed and colour-to-LED mapping.
package sms_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ON   = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam int unsigned LFSR_W   = 16;
   localparam int unsigned STEP_W   = 6;
   localparam int unsigned LED_W    = 4;

   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;
   // Feedback taps at bits 15, 13, 12 and 10
   localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;

   localparam logic [LED_W-1:0] LED_C0 = 4'b0001;
   localparam logic [LED_W-1:0] LED_C1 = 4'b0010;
   localparam logic [LED_W-1:0] LED_C2 = 4'b0100;
   localparam logic [LED_W-1:0] LED_C3 = 4'b1000;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

   // Colour is the two LSBs of the LFSR state
   function automatic logic [LED_W-1:0] led_of(input logic [LFSR_W-1:0] s);
      logic [LED_W-1:0] l;
      case (s[1:0])
         2'd0:    l = LED_C0;
         2'd1:    l = LED_C1;
         2'd2:    l = LED_C2;
         default: l = LED_C3;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/seq_player_if.sv
// Control/status bundle between the game controller and the sequence player.
interface seq_player_if;
   logic        start;
   logic [5:0]  round_len;
   logic [15:0] seed;
   logic [3:0]  led;
   logic [5:0]  step_idx;
   logic        busy;
   logic        done;

   modport master (output start, round_len, seed,
                   input  led, step_idx, busy, done);
   modport slave  (input  start, round_len, seed,
                   output led, step_idx, busy, done);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR shared by the player and the input checker; load wins over step.
module lfsr16 (
   input  logic        clk,
   input  logic        clr,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        step,
   output logic [15:0] q
);
   import sms_pkg::*;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)       q <= '0;
      else if (load) q <= seed;
      else if (step) q <= lfsr_next(q);
   end

endmodule

// File: rtl/seq_player.sv
// Plays the first round_len colours of the seeded LFSR sequence on four one-hot LEDs,
// each lit for ON_CYCLES then dark for OFF_CYCLES.
module seq_player #(
   parameter int unsigned ON_CYCLES    = 25000000,
   parameter int unsigned OFF_CYCLES   = 12500000,
   parameter int unsigned TIMER_W      = 26,
   parameter logic [15:0] DEFAULT_SEED = sms_pkg::DEFAULT_SEED
) (
   input  logic         clk,
   input  logic         clr,
   seq_player_if.slave  bus
);
   import sms_pkg::*;

   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

   state_t               state;
   logic [TIMER_W-1:0]   timer;
   logic [STEP_W-1:0]    len_q;
   logic [STEP_W-1:0]    step_q;
   logic [LED_W-1:0]     led_q;
   logic                 busy_q;
   logic                 done_q;
   logic [LFSR_W-1:0]    lfsr_q;
   logic [LFSR_W-1:0]    seed_c;
   logic                 load_c;
   logic                 step_c;

   assign seed_c = (bus.seed == '0) ? DEFAULT_SEED : bus.seed;
   assign load_c = (state == S_LOAD);
   // Advance exactly once per step, on the ON->GAP transition
   assign step_c = (state == S_ON) && (timer == '0);

   lfsr16 u_lfsr (
      .clk  (clk),
      .clr  (clr),
      .load (load_c),
      .seed (seed_c),
      .step (step_c),
      .q    (lfsr_q)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state  <= S_IDLE;
         timer  <= '0;
         len_q  <= '0;
         step_q <= '0;
         led_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               led_q  <= '0;
               busy_q <= 1'b0;
               if (bus.start) begin
                  if (bus.round_len != '0) begin
                     state  <= S_LOAD;
                     busy_q <= 1'b1;
                  end else begin
                     state  <= S_DONE;
                     done_q <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               // LFSR loads on this same edge, so take the first colour from the seed
               len_q  <= bus.round_len;
               step_q <= '0;
               timer  <= ON_LOAD;
               led_q  <= led_of(seed_c);
               state  <= S_ON;
            end
            S_ON: begin
               if (timer == '0) begin
                  led_q <= '0;
                  timer <= OFF_LOAD;
                  state <= S_GAP;
               end else begin
                  timer <= timer - TIMER_W'(1);
               end
            end
            S_GAP: begin
               if (timer != '0) begin
                  timer <= timer - TIMER_W'(1);
               end else if (step_q == len_q - STEP_W'(1)) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  step_q <= step_q + STEP_W'(1);
                  timer  <= ON_LOAD;
                  led_q  <= led_of(lfsr_q);
                  state  <= S_ON;
               end
            end
            S_DONE: begin
               led_q <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.led      = led_q;
   assign bus.step_idx = step_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: directed and random playbacks checked cycle by cycle
// against a timing/colour model derived from the seed.
module tb_seq_player;

   logic        clk = 1'b0;
   logic        clr;
   logic        start_a, start_b;
   logic [5:0]  rlen;
   logic [15:0] sd;
   int          total = 0;
   int          bad   = 0;
   logic [5:0]  last_a = '0;
   logic [5:0]  last_b = '0;

   seq_player_if a_if ();
   seq_player_if b_if ();

   assign a_if.start = start_a;  assign a_if.round_len = rlen;  assign a_if.seed = sd;
   assign b_if.start = start_b;  assign b_if.round_len = rlen;  assign b_if.seed = sd;

   seq_player #(.ON_CYCLES(4), .OFF_CYCLES(2), .TIMER_W(4)) dut_a (
      .clk(clk), .clr(clr), .bus(a_if));
   seq_player #(.ON_CYCLES(1), .OFF_CYCLES(1), .TIMER_W(2)) dut_b (
      .clk(clk), .clr(clr), .bus(b_if));

   always #5 clk = ~clk;

   task automatic check(input string tag, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   task automatic sample(input bit big, output logic [3:0] l, output logic [5:0] st,
                         output logic bz, output logic dn);
      l  = big ? b_if.led      : a_if.led;
      st = big ? b_if.step_idx : a_if.step_idx;
      bz = big ? b_if.busy     : a_if.busy;
      dn = big ? b_if.done     : a_if.done;
   endtask

   // One playback from start pulse until one idle cycle after done.
   // poke_at re-asserts start with round_len=2; clr_at aborts with clr.
   task automatic play(input bit big, input logic [5:0] len, input logic [15:0] seed_v,
                       input int poke_at, input int clr_at);
      int on_c, p, end_c, seg, ph;
      logic [1:0]  col [64];
      logic [15:0] s;
      logic [3:0]  l, e_led;
      logic [5:0]  st, e_st, prev;
      logic        bz, dn, e_bz;
      on_c  = big ? 1 : 4;
      p     = big ? 2 : 6;
      end_c = (len == 0) ? 1 : 2 + int'(len) * p;
      s = (seed_v == 16'h0) ? 16'hACE1 : seed_v;
      for (int k = 0; k < 64; k++) begin
         col[k] = s[1:0];
         s = model_next(s);
      end
      prev = big ? last_b : last_a;
      @(negedge clk);
      sample(big, l, st, bz, dn);
      check("idle_led", 0, 16'(l), 16'h0);
      check("idle_busy", 0, 16'(bz), 16'h0);
      rlen = len;
      sd   = seed_v;
      if (big) start_b = 1'b1; else start_a = 1'b1;
      for (int c = 1; c <= end_c + 1; c++) begin
         @(negedge clk);
         if (c == 1)       begin start_a = 1'b0; start_b = 1'b0; end
         if (c == poke_at) begin rlen = 6'd2; if (big) start_b = 1'b1; else start_a = 1'b1; end
         if (c == poke_at + 1) begin start_a = 1'b0; start_b = 1'b0; end
         if (c == 3) sd = 16'h5A5A;
         if (c == clr_at) begin
            clr = 1'b1;
            #1;
            sample(big, l, st, bz, dn);
            check("clr_led", c, 16'(l), 16'h0);
            check("clr_busy", c, 16'(bz), 16'h0);
            check("clr_step", c, 16'(st), 16'h0);
            check("clr_done", c, 16'(dn), 16'h0);
            #1 clr = 1'b0;
            last_a = '0;
            last_b = '0;
            return;
         end
         e_bz  = (len != 0) && (c < end_c);
         e_led = '0;
         e_st  = prev;
         if (len != 0 && c >= 2) begin
            seg = (c - 2) / p;
            ph  = (c - 2) % p;
            e_st = (seg >= int'(len)) ? len - 6'd1 : 6'(seg);
            if (c < end_c && ph < on_c) e_led = 4'(1 << col[seg]);
         end
         sample(big, l, st, bz, dn);
         check("led", c, 16'(l), 16'(e_led));
         check("step_idx", c, 16'(st), 16'(e_st));
         check("busy", c, 16'(bz), 16'(e_bz));
         check("done", c, 16'(dn), 16'(c == end_c));
         check("onehot", c, 16'($onehot0(l)), 16'h1);
      end
      if (len != 0) begin
         if (big) last_b = len - 6'd1; else last_a = len - 6'd1;
      end
   endtask

   initial begin
      logic [3:0] l;
      logic [5:0] st;
      logic       bz, dn;
      start_a = 1'b0; start_b = 1'b0; rlen = '0; sd = '0;
      clr = 1'b1;
      #1;
      sample(1'b0, l, st, bz, dn);
      check("rst_led", 0, 16'(l), 16'h0);
      check("rst_step", 0, 16'(st), 16'h0);
      check("rst_busy", 0, 16'(bz), 16'h0);
      check("rst_done", 0, 16'(dn), 16'h0);
      @(negedge clk);
      clr = 1'b0;

      play(1'b0, 6'd4, 16'h0001, -1, -1);      // colours 0010,0100,0001,0001
      play(1'b0, 6'd1, 16'h0000, -1, -1);      // default seed
      play(1'b0, 6'd1, 16'hACE1, -1, -1);
      play(1'b0, 6'd0, 16'h1234, -1, -1);      // zero length: done only
      play(1'b0, 6'd4, 16'h0001, 10, -1);      // restart attempt ignored
      play(1'b0, 6'd4, 16'hBEEF, -1, 5);       // clr mid-step
      play(1'b0, 6'd4, 16'hBEEF, -1, -1);      // replay from step 0
      play(1'b1, 6'd63, 16'h0001, -1, -1);     // longest round
      for (int i = 0; i < 8; i++) begin
         logic [5:0]  n;
         logic [15:0] s;
         n = 6'($urandom_range(1, 6));
         s = 16'($urandom);
         play(1'b0, n, s, (i == 3) ? 7 : -1, -1);
      end
      play(1'b1, 6'($urandom_range(10, 40)), 16'($urandom), -1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
